ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 32x16 data RAM.
- Requester A is the control unit (UC); requester B is the debug/loader port.
- Serialises accesses, drives the RAM address/data/write-enable, and returns read data with a valid pulse to the winning requester.
- Sits between the UC, the debug port and the RAM. The RAM is clocked by the same `clock`.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 5, RAM address width (32 words).
- RD_LAT, 1, RAM read latency in cycles from the address-capture edge to valid q; legal range 1..3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_a  in  1  A access request; level, held until gnt_a.
- we_a  in  1  A write (1) / read (0).
- addr_a  in  ADDR_W  A address.
- wdata_a  in  DATA_W  A write data.
- gnt_a  out  1  one-cycle pulse: A's access issued this cycle.
- rvalid_a  out  1  one-cycle pulse: rdata_a valid.
- rdata_a  out  DATA_W  A read data; holds its value between reads.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A ports, for requester B.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM data.
- ram_wren  out  1  to RAM write enable.
- ram_q  in  DATA_W  from RAM q.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0: gnt, rvalid, rdata, ram_address, ram_data, ram_wren, busy.
  - The round-robin pointer is set to A.
  - Any in-flight read is discarded and no rvalid is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE:
  - Sample req_a/req_b at the clock edge.
  - If any request is present, latch the winner's we/addr/wdata and go to ISSUE; otherwise stay in IDLE.
- ISSUE (cycle N):
  - gnt_x=1 for the winner.
  - ram_address and ram_data carry the latched values.
  - ram_wren=1 only if the access is a write.
  - Next state: write -> IDLE; read -> WAIT with the counter loaded to RD_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0 (cycle N+RD_LAT), register ram_q into rdata_x and go to RESP.
- RESP (cycle N+RD_LAT+1): rvalid_x=1 for one cycle, then go to IDLE.
- Timing:
  - Write: 2 cycles per access.
  - Read: RD_LAT+3 cycles per access, including IDLE.
  - Request-to-grant: 1 cycle minimum.
- Outside ISSUE:
  - ram_wren=0.
  - ram_address and ram_data hold their last values.
- Handshake:
  - Requester keeps req/we/addr/wdata stable until it sees gnt.
  - Requester deasserts req in the gnt cycle or re-requests; a req still high in the IDLE after completion is a new access.
  - A req dropped before it is sampled in IDLE produces no access.
  - Once sampled, the access completes regardless of req.
- Arbitration, default (fixed priority):
  - A beats B when both are requesting.
  - B may starve under continuous A traffic; this is accepted.
- Inputs are ignored outside IDLE; no queuing.
- The loser keeps its req asserted and is arbitrated again at the next IDLE.
- The address space is fully decoded (5 bits), so there is no out-of-range case.
- RD_LAT outside 1..3: behaviour undefined; the bench does not test it.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer records the last winner.
  - On simultaneous requests, the requester that did not win last is granted.
  - The pointer updates only on a grant.
  - After reset, the pointer makes A win the first tie.
- Undefined: fixed A-over-B priority; the pointer logic is absent.

Test Plan:
- Reset, then A write addr 5'h03, data 16'hBEEF -> in cycle N: gnt_a=1, ram_wren=1, ram_address=3, ram_data=BEEF; ram_wren=0 in N+1; busy high only in N.
- RD_LAT=1, A read addr 3 after that write -> gnt_a at N, rvalid_a=1 at N+2 with rdata_a=16'hBEEF, busy low at N+3.
- Fixed priority: A and B read addrs 1 and 2 in the same cycle (RAM preloaded 16'h1111/16'h2222) -> A served first (rdata_a=1111); gnt_b at the next ISSUE with rdata_b=2222; no overlap of gnt/rvalid.
- RAM_ARB_ROUND_ROBIN_EN defined, both req held high with writes -> grant order A,B,A,B,...; with the macro undefined, only A is granted.
- Reset asserted during WAIT of a B read -> all outputs 0 immediately; no rvalid_b afterwards; a following A write completes normally.
- req_b pulsed for one cycle while busy, then dropped -> no gnt_b and no RAM write to addr_b.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data RAM (A = control unit, B = debug/loader).
// Define RAM_ARB_ROUND_ROBIN_EN to alternate winners on ties; the default build gives A fixed priority.
module ram_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    // state | meaning
    // IDLE  | sample requests, latch the winner's access
    // ISSUE | access on the RAM pins, grant pulse to the winner
    // WAIT  | read latency countdown, capture ram_q on terminal count
    // RESP  | rvalid pulse to the winner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = 2;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                sel_b, sel_b_n;
    logic                op_we, op_we_n;
    logic                pick_b;
    logic                gnt_a_n, gnt_b_n, rvalid_a_n, rvalid_b_n, wren_n, busy_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   data_n, rdata_a_n, rdata_b_n;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic                prio_b, prio_b_n;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_b       <= 1'b0;
            op_we       <= 1'b0;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            rvalid_a    <= 1'b0;
            rvalid_b    <= 1'b0;
            rdata_a     <= '0;
            rdata_b     <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            prio_b      <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel_b       <= sel_b_n;
            op_we       <= op_we_n;
            gnt_a       <= gnt_a_n;
            gnt_b       <= gnt_b_n;
            rvalid_a    <= rvalid_a_n;
            rvalid_b    <= rvalid_b_n;
            rdata_a     <= rdata_a_n;
            rdata_b     <= rdata_b_n;
            ram_address <= addr_n;
            ram_data    <= data_n;
            ram_wren    <= wren_n;
            busy        <= busy_n;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            prio_b      <= prio_b_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sel_b_n    = sel_b;
        op_we_n    = op_we;
        addr_n     = ram_address;
        data_n     = ram_data;
        wren_n     = 1'b0;
        gnt_a_n    = 1'b0;
        gnt_b_n    = 1'b0;
        rvalid_a_n = 1'b0;
        rvalid_b_n = 1'b0;
        rdata_a_n  = rdata_a;
        rdata_b_n  = rdata_b;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        prio_b_n   = prio_b;
        pick_b     = req_b && (!req_a || prio_b);
`else
        pick_b     = req_b && !req_a;
`endif

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_n = ISSUE;
                    sel_b_n = pick_b;
                    op_we_n = pick_b ? we_b : we_a;
                    addr_n  = pick_b ? addr_b : addr_a;
                    data_n  = pick_b ? wdata_b : wdata_a;
                    wren_n  = pick_b ? we_b : we_a;
                    gnt_a_n = !pick_b;
                    gnt_b_n = pick_b;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    // priority passes to whoever did not just win
                    prio_b_n = !pick_b;
`endif
                end
            end
            ISSUE: begin
                if (op_we) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT;
                    cnt_n   = CNT_W'(RD_LAT);
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                // counter hits zero on this edge: ram_q is valid now
                if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                    if (sel_b) begin
                        rdata_b_n  = ram_q;
                        rvalid_b_n = 1'b1;
                    end else begin
                        rdata_a_n  = ram_q;
                        rvalid_a_n = 1'b1;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a 1-cycle-latency behavioural RAM.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [4:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren, busy;
    logic [15:0] rdata_a, rdata_b, ram_data, ram_q;
    logic [4:0]  ram_address;
    logic [15:0] mem [32];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_arbiter #(.DATA_W(16), .ADDR_W(5), .RD_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    // RAM model: address captured on the edge, q valid one cycle later
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            ram_q <= '0;
        end else begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_q <= mem[ram_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic exp_b;
        reset = 1'b1;
        req_a = 0; we_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; we_b = 0; addr_b = '0; wdata_b = '0;
        step(); step();

        check("rst_pulses", {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren, busy}, 0);
        check("rst_rdata", {rdata_a, rdata_b}, 0);
        check("rst_ram_bus", {ram_address, ram_data}, 0);
        reset = 1'b0;
        step();

        // A write 3 <= BEEF
        req_a = 1; we_a = 1; addr_a = 5'h03; wdata_a = 16'hBEEF;
        step();
        check("wr_gnt_a", gnt_a, 1);
        check("wr_gnt_b", gnt_b, 0);
        check("wr_wren", ram_wren, 1);
        check("wr_addr", ram_address, 5'h03);
        check("wr_data", ram_data, 16'hBEEF);
        check("wr_busy", busy, 1);
        req_a = 0;
        step();
        check("wr_wren_off", ram_wren, 0);
        check("wr_busy_off", busy, 0);
        check("wr_gnt_off", gnt_a, 0);
        check("wr_mem", mem[3], 16'hBEEF);

        // A read 3
        req_a = 1; we_a = 0; addr_a = 5'h03;
        step();
        check("rd_gnt_a", gnt_a, 1);
        check("rd_wren", ram_wren, 0);
        check("rd_addr", ram_address, 5'h03);
        req_a = 0;
        step();
        check("rd_wait", {busy, rvalid_a}, 2'b10);
        step();
        check("rd_rvalid", rvalid_a, 1);
        check("rd_rdata", rdata_a, 16'hBEEF);
        step();
        check("rd_done", {busy, rvalid_a}, 2'b00);
        check("rd_hold", rdata_a, 16'hBEEF);

        // reset pulse (pointer back to A, RAM cleared), then B preloads 1/2
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_b = 1; we_b = 1; addr_b = 5'h01; wdata_b = 16'h1111;
        step();
        check("bwr1_gnt", {gnt_a, gnt_b, ram_wren}, 3'b011);
        check("bwr1_addr", ram_address, 5'h01);
        req_b = 0;
        step();
        req_b = 1; we_b = 1; addr_b = 5'h02; wdata_b = 16'h2222;
        step();
        check("bwr2_gnt", {gnt_a, gnt_b, ram_wren}, 3'b011);
        req_b = 0;
        step();
        check("bwr_mem", {mem[1], mem[2]}, {16'h1111, 16'h2222});

        // simultaneous reads: A wins, B served at next IDLE
        req_a = 1; we_a = 0; addr_a = 5'h01;
        req_b = 1; we_b = 0; addr_b = 5'h02;
        step();
        check("tie_gnt", {gnt_a, gnt_b}, 2'b10);
        check("tie_addr_a", ram_address, 5'h01);
        req_a = 0;
        step();
        check("tie_wait", {gnt_a, gnt_b, rvalid_a, rvalid_b}, 0);
        step();
        check("tie_rv_a", {rvalid_a, rvalid_b}, 2'b10);
        check("tie_rdata_a", rdata_a, 16'h1111);
        step();
        check("tie_idle", {gnt_a, gnt_b, busy}, 0);
        step();
        check("tie_gnt_b", {gnt_a, gnt_b}, 2'b01);
        check("tie_addr_b", ram_address, 5'h02);
        req_b = 0;
        step();
        step();
        check("tie_rv_b", {rvalid_a, rvalid_b}, 2'b01);
        check("tie_rdata_b", rdata_b, 16'h2222);
        check("tie_rdata_a_hold", rdata_a, 16'h1111);
        step();

        // both hold write requests
        req_a = 1; we_a = 1; addr_a = 5'h0A; wdata_a = 16'hAAAA;
        req_b = 1; we_b = 1; addr_b = 5'h0B; wdata_b = 16'hBBBB;
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_b = i[0];
`else
            exp_b = 1'b0;
`endif
            step();
            check($sformatf("hold_gnt%0d", i), {gnt_a, gnt_b}, {~exp_b, exp_b});
            step();
            check($sformatf("hold_idle%0d", i), {gnt_a, gnt_b, busy}, 0);
        end
        req_a = 0; req_b = 0;
        step();
        check("hold_quiet", {gnt_a, gnt_b, busy}, 0);

        // reset during the WAIT of a B read
        req_b = 1; we_b = 0; addr_b = 5'h02;
        step();
        check("rstw_gnt_b", gnt_b, 1);
        req_b = 0;
        step();
        check("rstw_in_wait", busy, 1);
        reset = 1'b1;
        #1;
        check("rstw_pulses", {gnt_a, gnt_b, rvalid_a, rvalid_b, ram_wren, busy}, 0);
        check("rstw_rdata", {rdata_a, rdata_b}, 0);
        check("rstw_ram_bus", {ram_address, ram_data}, 0);
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("rstw_no_rv%0d", i), {rvalid_a, rvalid_b}, 0);
        end
        req_a = 1; we_a = 1; addr_a = 5'h07; wdata_a = 16'h1234;
        step();
        check("rstw_wr_gnt", {gnt_a, ram_wren}, 2'b11);
        check("rstw_wr_addr", ram_address, 5'h07);
        req_a = 0;
        step();
        check("rstw_wr_mem", mem[7], 16'h1234);
        check("rstw_wr_busy", busy, 0);

        // req_b pulsed only while busy must be ignored
        req_a = 1; we_a = 0; addr_a = 5'h07;
        step();
        check("pulse_gnt_a", gnt_a, 1);
        req_a = 0;
        req_b = 1; we_b = 1; addr_b = 5'h14; wdata_b = 16'h5555;
        step();
        req_b = 0;
        check("pulse_gnt_b0", gnt_b, 0);
        step();
        check("pulse_rv_a", rvalid_a, 1);
        check("pulse_rdata_a", rdata_a, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pulse_no_gnt_b%0d", i), {gnt_b, ram_wren}, 0);
        end
        check("pulse_mem", mem[20], 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
